mux_scan_sequencer: RTL and testbench
=====================================

Name: mux_scan_sequencer

Overview:
- Upstream control stage for the team's 8:1 select multiplexer: accepts a parallel word over a valid/ready handshake and holds it on the mux data inputs.
- Steps the mux select through every input, one step per DIV clocks.
- Samples the mux output at the end of each step and emits the result as a framed serial bit stream.
- Together with the mux, forms a parallel-to-serial converter; the mux stays purely combinational between this block's outputs and its mux_y input.

Parameters:
- SEL_W, 3, select width; N_IN = 2**SEL_W data inputs (8 by default).
- DIV, 4, clocks per select step; legal range 1..255.
- LSB_FIRST, 1, 1 = sel counts 0 up to N_IN-1; 0 = sel counts N_IN-1 down to 0.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  N_IN  parallel word to serialise.
- abort  input  1  synchronous cancel of the word in flight.
- mux_i  output  N_IN  registered word driven to the mux data inputs.
- mux_s  output  SEL_W  registered select driven to the mux.
- mux_y  input  1  mux output, combinational from mux_i/mux_s.
- ser_bit  output  1  sampled serial bit.
- ser_valid  output  1  one-cycle strobe marking ser_bit valid.
- ser_last  output  1  qualifies ser_valid on the final bit of a word.
- busy  output  1  a word is in flight, or its final strobe is pending.

Behaviour:
- Reset (async assert, sync release): state=IDLE; mux_i=0; mux_s=0; div_cnt=0; ser_bit=0; ser_valid=0; ser_last=0; busy=0. Reset mid-word discards the word and emits no further strobes.
- State IDLE:
  - in_ready=1.
  - On in_valid: latch in_data into mux_i; load mux_s with the start index (0 if LSB_FIRST, else N_IN-1); div_cnt=0; go to STEP.
- State STEP:
  - div_cnt increments each cycle.
  - Sample cycle is div_cnt==DIV-1. In it: ser_bit<=mux_y, ser_valid<=1 (next cycle), ser_last<=1 if mux_s is the end index; div_cnt<=0.
  - Not end index: mux_s steps by ±1.
  - End index with no new word: go to IDLE.
- Back-to-back: in_ready=1 also in the end-index sample cycle. If in_valid is high then, load the new word and start index and stay in STEP. There is no bubble, so strobes stay exactly DIV apart across word boundaries.
- Latency: word accepted at edge t0 → first ser_valid high in cycle t0+DIV+1, then every DIV cycles. N_IN strobes per word; the word occupies N_IN*DIV cycles.
- DIV=1: every STEP cycle is a sample cycle, giving N_IN consecutive strobes.
- abort:
  - In STEP, takes priority over sampling and acceptance: next cycle state=IDLE, div_cnt=0, no strobe for the partial step, and no ser_last for that word.
  - mux_i and mux_s hold their values.
  - A strobe already registered (abort in the cycle after a sample cycle) still appears.
  - Ignored in IDLE.
- ser_valid and ser_last are never high in consecutive cycles unless DIV=1.
- ser_last is only ever high together with ser_valid.
- busy = (state==STEP) OR ser_valid.
- mux_s never leaves 0..N_IN-1; no wrap-around within a word.

Decomposition:
- Package mux_scan_pkg holds:
  - state enum {IDLE, STEP};
  - localparam N_IN derivation;
  - start/end index functions keyed on LSB_FIRST.
- One natural sub-module, step_timer:
  - DIV counter that produces the sample-cycle pulse;
  - cleared on load and on abort.

Test Plan:
- DIV=4, LSB_FIRST=1, word 8'hA5 accepted at t0 → ser_valid at t0+5, +9, … +33; bits 1,0,1,0,0,1,0,1; ser_last only on the 8th; mux_s 0..7.
- LSB_FIRST=0, word 8'h81 → bits 1,0,0,0,0,0,0,1; mux_s 7 down to 0; busy drops the cycle after the last strobe.
- in_valid held high with words 8'h0F then 8'hF0 → 16 strobes spaced exactly 4 cycles apart, no gap; ser_last on strobes 8 and 16; in_ready high only in IDLE and in end-index sample cycles.
- abort asserted after the 3rd strobe of 8'hFF → no further strobes, no ser_last, state IDLE; next word 8'h01 serialises correctly from index 0.
- rst_n pulsed low asynchronously mid-word (between edges) → all outputs 0 immediately; no strobe after release until a new accept.
- DIV=1, word 8'h3C → 8 consecutive ser_valid cycles with bits 0,0,1,1,1,1,0,0; ser_last on the 8th.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg
//   Shared types and helpers for the mux scan sequencer.
//   - state_e     : sequencer FSM state (IDLE / STEP)
//   - ser_out_t   : registered serial output bundle (valid, last, data)
//   - n_in()      : number of mux data inputs for a given select width
//   - start_idx() : first select value of a word, by scan direction
//   - end_idx()   : final select value of a word, by scan direction
package mux_scan_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        STEP = 1'b1
    } state_e;

    typedef struct packed {
        logic valid;
        logic last;
        logic data;
    } ser_out_t;

    localparam int DEF_SEL_W = 3;
    // Step counter is wide enough for the largest legal DIV (255).
    localparam int CNT_W     = 8;

    function automatic int n_in(input int sel_w);
        return 2 ** sel_w;
    endfunction

    function automatic int start_idx(input int sel_w, input bit lsb_first);
        return lsb_first ? 0 : n_in(sel_w) - 1;
    endfunction

    function automatic int end_idx(input int sel_w, input bit lsb_first);
        return lsb_first ? n_in(sel_w) - 1 : 0;
    endfunction

endpackage

// File: rtl/mux_scan_sequencer_step_timer.sv
// step_timer
//   Clocks-per-step counter. While run is high it counts 0..DIV-1 and
//   raises sample combinationally in the last cycle of each step, then
//   wraps to 0. Outside STEP, and on clr (new word / abort), it is held
//   at 0 so the next step always starts from a full DIV count.
//   Ports:
//     clk, rst_n : clock, async active-low reset
//     run        : sequencer is in STEP
//     clr        : restart the step count next cycle
//     sample     : current cycle is the last cycle of a step
module step_timer
    import mux_scan_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clr,
    output logic sample
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign sample = run && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || !run || sample) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer
//   Front end of a parallel-to-serial converter built around an external
//   combinational N_IN:1 mux. A word accepted on the in_valid/in_ready
//   handshake is held on mux_i while mux_s walks every input, one step per
//   DIV clocks. The mux output is sampled in the last cycle of each step
//   and presented one cycle later as a ser_valid strobe (ser_last on the
//   final bit). A new word can be taken in the final sample cycle, so
//   consecutive words stream with no gap between strobes.
//   Ports:
//     clk, rst_n          : clock, async active-low reset
//     in_valid/in_ready   : word handshake; in_data is the word
//     abort               : drop the word in flight (ignored when idle)
//     mux_i, mux_s        : registered mux data inputs and select
//     mux_y               : mux output, combinational from mux_i/mux_s
//     ser_bit/valid/last  : registered serial output
//     busy                : word in flight or final strobe pending
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int  SEL_W     = DEF_SEL_W,
    parameter int  DIV       = 4,
    parameter bit  LSB_FIRST = 1'b1,
    localparam int N_IN      = n_in(SEL_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_data,
    input  logic             abort,
    output logic [N_IN-1:0]  mux_i,
    output logic [SEL_W-1:0] mux_s,
    input  logic             mux_y,
    output logic             ser_bit,
    output logic             ser_valid,
    output logic             ser_last,
    output logic             busy
);

    localparam int               START_I = start_idx(SEL_W, LSB_FIRST);
    localparam int               END_I   = end_idx(SEL_W, LSB_FIRST);
    localparam logic [SEL_W-1:0] START_S = START_I[SEL_W-1:0];
    localparam logic [SEL_W-1:0] END_S   = END_I[SEL_W-1:0];

    state_e           state_q, state_d;
    logic [N_IN-1:0]  mux_i_q, mux_i_d;
    logic [SEL_W-1:0] mux_s_q, mux_s_d;
    ser_out_t         ser_q, ser_d;

    logic run;
    logic sample;
    logic at_end;
    logic load;
    logic clr;

    assign run    = (state_q == STEP);
    assign at_end = (mux_s_q == END_S);
    // Restart the step count on a new word and on abort; an abort mid-step
    // must not leave a partial count behind for the next word.
    assign clr    = load || (run && abort);

    step_timer #(
        .DIV(DIV)
    ) u_step_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (run),
        .clr   (clr),
        .sample(sample)
    );

    // Ready when idle, or in the final sample cycle of a word so the next
    // word follows without a bubble. Abort wins over acceptance.
    assign in_ready = (state_q == IDLE) || (run && sample && at_end && !abort);

    always_comb begin
        state_d     = state_q;
        mux_i_d     = mux_i_q;
        mux_s_d     = mux_s_q;
        ser_d       = '0;
        ser_d.data  = ser_q.data;
        load        = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    load = 1'b1;
                end
            end
            STEP: begin
                if (abort) begin
                    // mux_i/mux_s hold; no strobe for the partial step.
                    state_d = IDLE;
                end else if (sample) begin
                    ser_d.data  = mux_y;
                    ser_d.valid = 1'b1;
                    ser_d.last  = at_end;
                    if (!at_end) begin
                        mux_s_d = LSB_FIRST ? mux_s_q + 1'b1 : mux_s_q - 1'b1;
                    end else if (in_valid) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            mux_i_d = in_data;
            mux_s_d = START_S;
            state_d = STEP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mux_i_q <= '0;
            mux_s_q <= '0;
            ser_q   <= '0;
        end else begin
            state_q <= state_d;
            mux_i_q <= mux_i_d;
            mux_s_q <= mux_s_d;
            ser_q   <= ser_d;
        end
    end

    assign mux_i     = mux_i_q;
    assign mux_s     = mux_s_q;
    assign ser_bit   = ser_q.data;
    assign ser_valid = ser_q.valid;
    assign ser_last  = ser_q.last;
    // Stay busy through the strobe of the final bit.
    assign busy      = run || ser_q.valid;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
`timescale 1ns/1ps
// Bench: three instances share one stimulus stream
//   0: DIV=4 LSB_FIRST=1   1: DIV=4 LSB_FIRST=0   2: DIV=1 LSB_FIRST=1
// A per-instance model keeps a queue of (cycle, bit, last) strobes scheduled
// from each accepted word and trims it on abort/reset.
module tb_mux_scan_sequencer;

    localparam int NI = 3;

    typedef struct {
        int   t;
        logic b;
        logic l;
    } exp_t;

    typedef struct {
        logic [7:0] d;
        logic [7:0] exp_l;   // emitted bits, first bit leftmost, LSB-first
        logic [7:0] exp_m;   // emitted bits, first bit leftmost, MSB-first
    } vec_t;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data  = 8'h00;
    logic       abort    = 1'b0;

    logic       in_ready_w  [NI];
    logic [7:0] mux_i_w     [NI];
    logic [2:0] mux_s_w     [NI];
    logic       mux_y_w     [NI];
    logic       ser_bit_w   [NI];
    logic       ser_valid_w [NI];
    logic       ser_last_w  [NI];
    logic       busy_w      [NI];

    always #5 clk = ~clk;

    mux_scan_sequencer #(.SEL_W(3), .DIV(4), .LSB_FIRST(1'b1)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[0]),
        .in_data(in_data), .abort(abort), .mux_i(mux_i_w[0]), .mux_s(mux_s_w[0]),
        .mux_y(mux_y_w[0]), .ser_bit(ser_bit_w[0]), .ser_valid(ser_valid_w[0]),
        .ser_last(ser_last_w[0]), .busy(busy_w[0]));

    mux_scan_sequencer #(.SEL_W(3), .DIV(4), .LSB_FIRST(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[1]),
        .in_data(in_data), .abort(abort), .mux_i(mux_i_w[1]), .mux_s(mux_s_w[1]),
        .mux_y(mux_y_w[1]), .ser_bit(ser_bit_w[1]), .ser_valid(ser_valid_w[1]),
        .ser_last(ser_last_w[1]), .busy(busy_w[1]));

    mux_scan_sequencer #(.SEL_W(3), .DIV(1), .LSB_FIRST(1'b1)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[2]),
        .in_data(in_data), .abort(abort), .mux_i(mux_i_w[2]), .mux_s(mux_s_w[2]),
        .mux_y(mux_y_w[2]), .ser_bit(ser_bit_w[2]), .ser_valid(ser_valid_w[2]),
        .ser_last(ser_last_w[2]), .busy(busy_w[2]));

    // The external 8:1 mux.
    for (genvar g = 0; g < NI; g++) begin : g_mux
        assign mux_y_w[g] = mux_i_w[g][mux_s_w[g]];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         errors = 0;
    int         checks = 0;
    exp_t       expq  [NI][$];
    int         st_n  [NI];
    int         st_t  [NI][64];
    logic       st_b  [NI][64];
    logic       st_l  [NI][64];
    int         mux_a [NI];
    logic [7:0] mux_d [NI];
    bit         acc   [NI];
    bit         mux_chk = 1'b0;

    function automatic int div_of(input int i);
        return (i == 2) ? 1 : 4;
    endfunction

    function automatic bit lsb_of(input int i);
        return (i != 1);
    endfunction

    task automatic chk(input string name, input int i, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s inst=%0d cyc=%0d got=%0d exp=%0d", name, i, cyc, act, exp);
        end
    endtask

    // Called once per cycle at the falling edge.
    task automatic model_step();
        for (int i = 0; i < NI; i++) begin
            int n, maxt, k, idx, exp_s;
            bit step, rdy, sv;
            acc[i] = 1'b0;
            if (!rst_n) begin
                expq[i].delete();
                mux_a[i] = -1;
            end else begin
                n    = expq[i].size();
                maxt = (n > 0) ? expq[i][n-1].t : -1;
                step = (n > 0) && (maxt > cyc);
                rdy  = !step || ((maxt == cyc + 1) && !abort);
                sv   = 1'b0;
                if (n > 0) sv = (expq[i][0].t == cyc);
                chk("in_ready", i, int'(in_ready_w[i]), int'(rdy));
                chk("busy", i, int'(busy_w[i]), int'(n > 0));
                chk("ser_valid", i, int'(ser_valid_w[i]), int'(sv));
                if (sv) begin
                    chk("ser_bit", i, int'(ser_bit_w[i]), int'(expq[i][0].b));
                    chk("ser_last", i, int'(ser_last_w[i]), int'(expq[i][0].l));
                    void'(expq[i].pop_front());
                end else begin
                    chk("ser_last_alone", i, int'(ser_last_w[i]), 0);
                end
                if (ser_valid_w[i]) begin
                    st_t[i][st_n[i] % 64] = cyc;
                    st_b[i][st_n[i] % 64] = ser_bit_w[i];
                    st_l[i][st_n[i] % 64] = ser_last_w[i];
                    st_n[i]++;
                end
                if (mux_chk && mux_a[i] >= 0 && cyc > mux_a[i]) begin
                    k = (cyc - mux_a[i] - 1) / div_of(i);
                    if (k > 7) k = 7;
                    exp_s = lsb_of(i) ? k : 7 - k;
                    chk("mux_s", i, int'(mux_s_w[i]), exp_s);
                    chk("mux_i", i, int'(mux_i_w[i]), int'(mux_d[i]));
                end
                if (abort && step) begin
                    expq[i].delete();
                    mux_a[i] = -1;
                end else if (in_valid && rdy) begin
                    acc[i]   = 1'b1;
                    mux_a[i] = cyc;
                    mux_d[i] = in_data;
                    for (int j = 0; j < 8; j++) begin
                        idx = lsb_of(i) ? j : 7 - j;
                        expq[i].push_back('{t: cyc + div_of(i) * (j + 1) + 1,
                                            b: in_data[idx], l: (j == 7)});
                    end
                end
            end
        end
    endtask

    task automatic cyc_drive(input logic v, input logic [7:0] d, input logic a);
        in_valid = v;
        in_data  = d;
        abort    = a;
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        int w;
        w = 0;
        while ((busy_w[0] || busy_w[1] || busy_w[2]) && w < budget) begin
            cyc_drive(1'b0, 8'h00, 1'b0);
            w++;
        end
        checks++;
        if (busy_w[0] || busy_w[1] || busy_w[2]) begin
            errors++;
            $display("FAIL wait_idle timeout cyc=%0d busy=%0b%0b%0b exp=000",
                     cyc, busy_w[0], busy_w[1], busy_w[2]);
        end
    endtask

    task automatic check_word(input int i, input int n0, input int a, input logic [7:0] exp);
        logic [7:0] got;
        int lasts;
        got   = '0;
        lasts = 0;
        chk("strobe_cnt", i, st_n[i] - n0, 8);
        for (int k = 0; k < 8; k++) begin
            got[7-k] = st_b[i][(n0 + k) % 64];
            if (st_l[i][(n0 + k) % 64]) lasts++;
        end
        chk("stream", i, int'(got), int'(exp));
        chk("last_cnt", i, lasts, 1);
        chk("last_pos", i, int'(st_l[i][(n0 + 7) % 64]), 1);
        chk("first_lat", i, st_t[i][n0 % 64] - a, div_of(i) + 1);
        chk("span", i, st_t[i][(n0 + 7) % 64] - st_t[i][n0 % 64], 7 * div_of(i));
    endtask

    task automatic check_outputs_reset();
        for (int i = 0; i < NI; i++) begin
            chk("rst_busy", i, int'(busy_w[i]), 0);
            chk("rst_ser_valid", i, int'(ser_valid_w[i]), 0);
            chk("rst_ser_last", i, int'(ser_last_w[i]), 0);
            chk("rst_ser_bit", i, int'(ser_bit_w[i]), 0);
            chk("rst_mux_s", i, int'(mux_s_w[i]), 0);
            chk("rst_mux_i", i, int'(mux_i_w[i]), 0);
            chk("rst_in_ready", i, int'(in_ready_w[i]), 1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [5];
        int          n0 [NI];
        int          w, lasts;
        logic [15:0] got16;

        vecs[0] = '{d: 8'h01, exp_l: 8'b1000_0000, exp_m: 8'b0000_0001};
        vecs[1] = '{d: 8'hA5, exp_l: 8'b1010_0101, exp_m: 8'b1010_0101};
        vecs[2] = '{d: 8'h81, exp_l: 8'b1000_0001, exp_m: 8'b1000_0001};
        vecs[3] = '{d: 8'h3C, exp_l: 8'b0011_1100, exp_m: 8'b0011_1100};
        vecs[4] = '{d: 8'hC5, exp_l: 8'b1010_0011, exp_m: 8'b1100_0101};

        for (int i = 0; i < NI; i++) begin
            mux_a[i] = -1;
            st_n[i]  = 0;
        end

        // Power-on reset
        #2 rst_n = 1'b0;
        #1;
        check_outputs_reset();
        repeat (2) cyc_drive(1'b0, 8'h00, 1'b0);
        rst_n = 1'b1;
        cyc_drive(1'b0, 8'h00, 1'b0);

        // Abort after the third strobe of 8'hFF
        wait_idle(200);
        for (int i = 0; i < NI; i++) n0[i] = st_n[i];
        cyc_drive(1'b1, 8'hFF, 1'b0);
        w = 0;
        while ((st_n[0] - n0[0]) < 3 && w < 40) begin
            cyc_drive(1'b0, 8'h00, 1'b0);
            w++;
        end
        chk("abort_pre_cnt", 0, st_n[0] - n0[0], 3);
        cyc_drive(1'b0, 8'h00, 1'b1);
        chk("abort_busy", 0, int'(busy_w[0]), 0);
        chk("abort_ready", 0, int'(in_ready_w[0]), 1);
        repeat (12) cyc_drive(1'b0, 8'h00, 1'b0);
        chk("abort_post_cnt", 0, st_n[0] - n0[0], 3);
        lasts = 0;
        for (int k = 0; k < 3; k++) if (st_l[0][(n0[0] + k) % 64]) lasts++;
        chk("abort_no_last", 0, lasts, 0);

        // Single words from the vector table (first one follows the abort)
        mux_chk = 1'b1;
        for (int v = 0; v < 5; v++) begin
            wait_idle(200);
            for (int i = 0; i < NI; i++) n0[i] = st_n[i];
            cyc_drive(1'b1, vecs[v].d, 1'b0);
            wait_idle(200);
            check_word(0, n0[0], mux_a[0], vecs[v].exp_l);
            check_word(1, n0[1], mux_a[1], vecs[v].exp_m);
            check_word(2, n0[2], mux_a[2], vecs[v].exp_l);
        end
        mux_chk = 1'b0;

        // Back-to-back: 8'h0F then 8'hF0 with in_valid held high
        wait_idle(200);
        for (int i = 0; i < NI; i++) n0[i] = st_n[i];
        cyc_drive(1'b1, 8'h0F, 1'b0);
        w = 0;
        do begin
            cyc_drive(1'b1, 8'hF0, 1'b0);
            w++;
        end while (!acc[0] && w < 60);
        chk("b2b_accept", 0, int'(acc[0]), 1);
        wait_idle(200);
        for (int i = 0; i < 2; i++) begin
            chk("b2b_cnt", i, st_n[i] - n0[i], 16);
            got16 = '0;
            lasts = 0;
            for (int k = 0; k < 16; k++) begin
                got16[15-k] = st_b[i][(n0[i] + k) % 64];
                if (st_l[i][(n0[i] + k) % 64]) lasts++;
                if (k > 0)
                    chk("b2b_gap", i, st_t[i][(n0[i] + k) % 64] - st_t[i][(n0[i] + k - 1) % 64], 4);
            end
            chk("b2b_stream", i, int'(got16),
                (i == 0) ? int'(16'b1111_0000_0000_1111) : int'(16'b0000_1111_1111_0000));
            chk("b2b_last_cnt", i, lasts, 2);
            chk("b2b_last8", i, int'(st_l[i][(n0[i] + 7) % 64]), 1);
            chk("b2b_last16", i, int'(st_l[i][(n0[i] + 15) % 64]), 1);
        end

        // Asynchronous reset mid-word
        wait_idle(200);
        cyc_drive(1'b1, 8'hA5, 1'b0);
        repeat (10) cyc_drive(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < NI; i++) n0[i] = st_n[i];
        #1 rst_n = 1'b0;
        #1;
        check_outputs_reset();
        @(negedge clk);
        model_step();
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (50) cyc_drive(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < NI; i++) chk("rst_no_strobe", i, st_n[i] - n0[i], 0);

        // Random traffic against the model
        for (int r = 0; r < 1500; r++) begin
            cyc_drive($urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 30) == 0);
        end
        wait_idle(200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
